// File: rtl/bcrypt_pkg.sv
// Shared definitions for the bcrypt host-side block: top FSM states,
// per-core BRAM region layout and the host-visible completion value.
package bcrypt_pkg;

   // Top-level job sequencing states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Byte offsets inside one core's BRAM region.
   localparam logic [31:0] P_ARRAY    = 32'h0000_0000;  // 18-word P array
   localparam logic [31:0] P_S0       = 32'h0000_0048;  // four 256-word S-boxes
   localparam logic [31:0] P_EXP_KEY  = 32'h0000_1048;  // 18-word expanded key
   localparam logic [31:0] P_SALT     = 32'h0000_1090;  // 16-byte salt
   localparam logic [31:0] COUNT_ADDR = 32'h0000_10A0;  // cost / iteration count

   // Distance between consecutive core regions; must exceed COUNT_ADDR + 4.
   localparam logic [31:0] DEF_REGION_STRIDE = 32'h0000_1100;

   // Value presented on the done register once every enabled core finished.
   localparam logic [31:0] DONE_VALUE = 32'h0000_00FF;

   // Base byte address of a core's region in the shared BRAM.
   function automatic logic [31:0] region_base(input int unsigned idx,
                                               input logic [31:0] stride);
      return stride * 32'(idx);
   endfunction

endpackage

// File: rtl/bcrypt_arbiter_rr.sv
// Round-robin owner selection for the shared host BRAM port.
// A grant is registered, held for as long as the owner keeps its request
// high, and followed by a quiet gap so in-flight read data still lands at
// the previous owner before another core can drive the port.
module rr_arbiter #(
   parameter int N          = 4,
   parameter int RD_LATENCY = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         rel,   // drop ownership and gap at once (job abort)
   input  logic [N-1:0] req,
   output logic [N-1:0] gnt
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;
   localparam int GW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

   // The release edge itself already produces one idle cycle, so the counter
   // only has to cover the remaining RD_LATENCY-1 cycles.
   localparam logic [GW-1:0] GUARD_LOAD = (RD_LATENCY > 1) ? GW'(RD_LATENCY - 1) : '0;

   logic [PW-1:0] ptr;       // index of the most recently granted core
   logic [GW-1:0] guard;     // idle cycles still owed after a release
   logic          pick_vld;
   logic [PW-1:0] pick;
   logic [PW-1:0] cand;
   logic          owner_holds;

   assign owner_holds = |(gnt & req);

   // Search the requesters starting just after the last granted index.
   always_comb begin
      pick_vld = 1'b0;
      pick     = '0;
      cand     = '0;
      for (int k = 1; k <= N; k++) begin
         cand = PW'((int'(ptr) + k) % N);
         if (!pick_vld && req[cand]) begin
            pick_vld = 1'b1;
            pick     = cand;
         end
      end
   end

   // Grant register, round-robin pointer and post-release guard counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         gnt   <= '0;
         ptr   <= PW'(N - 1);
         guard <= '0;
      end else if (rel) begin
         gnt   <= '0;
         guard <= '0;
      end else if (|gnt) begin
         if (!owner_holds) begin
            gnt   <= '0;
            guard <= GUARD_LOAD;
         end
      end else if (guard != '0) begin
         guard <= guard - 1'b1;
      end else if (pick_vld) begin
         gnt <= N'(1) << pick;
         ptr <= pick;
      end
   end

endmodule

// File: rtl/bcrypt_arbiter.sv
// Host-side controller for a group of bcrypt_loop cores: sequences a job
// (idle -> run -> done), drives per-core run levels and shares one host
// BRAM port between the cores through a round-robin arbiter.
module bcrypt_arbiter
   import bcrypt_pkg::*;
#(
   parameter int          NUM_CORES     = 4,
   parameter logic [31:0] REGION_STRIDE = DEF_REGION_STRIDE,
   parameter int          RD_LATENCY    = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [31:0]            host_start,
   output logic [NUM_CORES-1:0]   core_run,
   input  logic [NUM_CORES-1:0]   core_done,
   input  logic [NUM_CORES-1:0]   core_req,
   output logic [NUM_CORES-1:0]   core_gnt,
   input  logic [NUM_CORES*32-1:0] core_addr,
   input  logic [NUM_CORES*4-1:0] core_we,
   input  logic [NUM_CORES*32-1:0] core_wrdata,
   output logic [31:0]            core_rddata,
   output logic                   BRAM_Clk_A,
   output logic                   BRAM_Rst_A,
   output logic                   BRAM_En_A,
   output logic [3:0]             BRAM_WE_A,
   output logic [31:0]            BRAM_Addr_A,
   output logic [31:0]            BRAM_WrData_A,
   input  logic [31:0]            BRAM_RdData_A,
   output logic [31:0]            done
);

   state_t                 state;
   logic [NUM_CORES-1:0]   mask;
   logic                   host_go;
   logic [NUM_CORES-1:0]   start_mask;
   logic                   all_done;
   logic [NUM_CORES-1:0]   eligible;

   assign host_go    = |host_start;
   assign start_mask = host_start[NUM_CORES-1:0];
   assign all_done   = ((core_done & mask) == mask);

   // Only cores that are currently running may compete for the port.
   assign eligible = core_req & core_run;

   // Port A is permanently enabled and clocked with the fabric clock.
   assign BRAM_Clk_A  = clk;
   assign BRAM_Rst_A  = 1'b0;
   assign BRAM_En_A   = 1'b1;
   assign core_rddata = BRAM_RdData_A;

   // Job sequencer; a zero host_start aborts from any state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         mask     <= '0;
         core_run <= '0;
         done     <= '0;
      end else if (!host_go) begin
         state    <= ST_IDLE;
         mask     <= '0;
         core_run <= '0;
         done     <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               done <= '0;
               if (start_mask == '0) begin
                  // Nothing to run: completion is reported from DONE itself.
                  mask     <= '0;
                  core_run <= '0;
                  state    <= ST_DONE;
               end else begin
                  mask     <= start_mask;
                  core_run <= start_mask;
                  state    <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (all_done) begin
                  done  <= DONE_VALUE;
                  state <= ST_DONE;
               end
            end
            ST_DONE: begin
               // Cores keep their run level so they hold their done state.
               done <= DONE_VALUE;
            end
            default: begin
               state <= ST_IDLE;
               done  <= '0;
            end
         endcase
      end
   end

   rr_arbiter #(
      .N          (NUM_CORES),
      .RD_LATENCY (RD_LATENCY)
   ) u_rr (
      .clk (clk),
      .rst (rst),
      .rel (!host_go),
      .req (eligible),
      .gnt (core_gnt)
   );

   // Steer the owning core onto port A, relocated into its own region.
   always_comb begin
      BRAM_Addr_A   = '0;
      BRAM_WE_A     = '0;
      BRAM_WrData_A = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         if (core_gnt[i]) begin
            BRAM_Addr_A   = core_addr[i*32 +: 32] + region_base(i, REGION_STRIDE);
            BRAM_WE_A     = core_we[i*4 +: 4];
            BRAM_WrData_A = core_wrdata[i*32 +: 32];
         end
      end
   end

endmodule

// File: tb/tb_bcrypt_arbiter.sv
// Bench for bcrypt_arbiter: directed job scenarios with literal expectations
// followed by randomized traffic, all cross-checked every cycle against a
// behavioural model of the job sequencer and the shared port.
module tb_bcrypt_arbiter;

   localparam int          N      = 4;
   localparam int          RDL    = 2;
   localparam logic [31:0] STRIDE = 32'h1100;

   logic            clk = 1'b0;
   logic            rst;
   logic [31:0]     host_start;
   logic [N-1:0]    core_run, core_done, core_req, core_gnt;
   logic [N*32-1:0] core_addr, core_wrdata;
   logic [N*4-1:0]  core_we;
   logic [31:0]     core_rddata;
   logic            BRAM_Clk_A, BRAM_Rst_A, BRAM_En_A;
   logic [3:0]      BRAM_WE_A;
   logic [31:0]     BRAM_Addr_A, BRAM_WrData_A, BRAM_RdData_A, done;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   bcrypt_arbiter #(
      .NUM_CORES     (N),
      .REGION_STRIDE (STRIDE),
      .RD_LATENCY    (RDL)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .host_start    (host_start),
      .core_run      (core_run),
      .core_done     (core_done),
      .core_req      (core_req),
      .core_gnt      (core_gnt),
      .core_addr     (core_addr),
      .core_we       (core_we),
      .core_wrdata   (core_wrdata),
      .core_rddata   (core_rddata),
      .BRAM_Clk_A    (BRAM_Clk_A),
      .BRAM_Rst_A    (BRAM_Rst_A),
      .BRAM_En_A     (BRAM_En_A),
      .BRAM_WE_A     (BRAM_WE_A),
      .BRAM_Addr_A   (BRAM_Addr_A),
      .BRAM_WrData_A (BRAM_WrData_A),
      .BRAM_RdData_A (BRAM_RdData_A),
      .done          (done)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // phase: 0 idle, 1 running, 2 finished
   int           m_phase;
   logic [N-1:0] m_mask, m_run;
   int           m_owner;   // -1 when the port is free
   int           m_last;    // last core that received the port
   int           m_since;   // idle cycles shown since the last release
   bit           m_done;

   task automatic model_step();
      logic [N-1:0] elig;
      if (rst) begin
         m_phase = 0; m_mask = '0; m_run = '0; m_owner = -1;
         m_last = N - 1; m_since = 1000; m_done = 1'b0;
      end else if (host_start == 32'd0) begin
         m_phase = 0; m_run = '0; m_owner = -1; m_since = 1000; m_done = 1'b0;
      end else begin
         elig = core_req & m_run;
         if (m_owner >= 0) begin
            if (!elig[m_owner]) begin
               m_owner = -1;
               m_since = 1;
            end
         end else if (m_since >= RDL && elig != '0) begin
            for (int k = 1; k <= N; k++)
               if (m_owner < 0 && elig[(m_last + k) % N]) m_owner = (m_last + k) % N;
            m_last = m_owner;
         end else if (m_since < 1000) begin
            m_since++;
         end
         case (m_phase)
            0: begin
               m_done = 1'b0;
               if (host_start[N-1:0] == '0) m_phase = 2;
               else begin
                  m_mask  = host_start[N-1:0];
                  m_run   = m_mask;
                  m_phase = 1;
               end
            end
            1: if ((core_done & m_mask) == m_mask) begin
               m_phase = 2;
               m_done  = 1'b1;
            end
            default: m_done = 1'b1;
         endcase
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   // ---------------- per-cycle comparison ----------------
   task automatic compare();
      logic [N-1:0] eg;
      logic [31:0]  ea, ed;
      logic [3:0]   ew;
      eg = '0; ea = '0; ed = '0; ew = '0;
      if (m_owner >= 0) begin
         eg = N'(1) << m_owner;
         ea = core_addr[m_owner*32 +: 32] + STRIDE * 32'(m_owner);
         ew = core_we[m_owner*4 +: 4];
         ed = core_wrdata[m_owner*32 +: 32];
      end
      check("core_run", 32'(core_run), 32'(m_run));
      check("core_gnt", 32'(core_gnt), 32'(eg));
      check("done", done, m_done ? 32'hFF : 32'h0);
      check("bram_addr", BRAM_Addr_A, ea);
      check("bram_we", 32'(BRAM_WE_A), 32'(ew));
      check("bram_wrdata", BRAM_WrData_A, ed);
      check("rddata", core_rddata, BRAM_RdData_A);
      check("bram_ctl", {29'd0, BRAM_Clk_A, BRAM_Rst_A, BRAM_En_A}, {29'd0, clk, 2'b01});
   endtask

   initial forever begin
      @(negedge clk);
      if (chk_en) compare();
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // ---------------- stimulus ----------------
   int burst [N];

   initial begin
      rst = 1'b1; host_start = '0; core_req = '0; core_done = '0;
      core_addr = '0; core_we = '0; core_wrdata = '0; BRAM_RdData_A = '0;
      for (int i = 0; i < N; i++) burst[i] = 0;
      tick(); tick();
      check("rst_run", 32'(core_run), 32'h0);
      check("rst_gnt", 32'(core_gnt), 32'h0);
      check("rst_done", done, 32'h0);
      check("rst_we", 32'(BRAM_WE_A), 32'h0);
      chk_en = 1'b1;

      // Two cores collide; core 0 wins, core 1 waits out the read guard.
      rst = 1'b0; host_start = 32'h3; tick();
      check("c1_run", 32'(core_run), 32'h3);
      core_req = 4'b0011; tick();
      check("c1_gnt0", 32'(core_gnt), 32'h1);
      tick();
      check("c1_hold", 32'(core_gnt), 32'h1);
      core_req = 4'b0010; tick();
      check("c1_gap1", 32'(core_gnt), 32'h0);
      tick();
      check("c1_gap2", 32'(core_gnt), 32'h0);
      tick();
      check("c1_gnt1", 32'(core_gnt), 32'h2);
      core_req = '0; host_start = '0; tick();

      // Core 2 address relocation and write-enable pass-through.
      host_start = 32'h4; tick();
      core_req = 4'b0100; core_addr[64 +: 32] = 32'd4260;
      core_we[8 +: 4] = 4'hF; core_wrdata[64 +: 32] = 32'hDEADBEEF; tick();
      check("c2_gnt", 32'(core_gnt), 32'h4);
      check("c2_addr", BRAM_Addr_A, 32'h32A4);
      check("c2_we", 32'(BRAM_WE_A), 32'hF);
      check("c2_wd", BRAM_WrData_A, 32'hDEADBEEF);
      core_req = '0; tick();
      check("c2_we_rel", 32'(BRAM_WE_A), 32'h0);
      check("c2_addr_rel", BRAM_Addr_A, 32'h0);
      host_start = '0; core_we = '0; tick();

      // Completion only after the last enabled core reports done.
      host_start = 32'hF; tick();
      core_done = 4'b1000; tick(); check("c3_d3", done, 32'h0);
      core_done = 4'b1010; tick(); check("c3_d1", done, 32'h0);
      core_done = 4'b1011; tick(); check("c3_d0", done, 32'h0);
      core_done = 4'b1111; tick(); check("c3_d2", done, 32'hFF);
      tick(); check("c3_hold", done, 32'hFF);
      check("c3_run", 32'(core_run), 32'hF);

      // Reset while finished, then the job restarts.
      rst = 1'b1; tick();
      check("c6_run", 32'(core_run), 32'h0);
      check("c6_done", done, 32'h0);
      check("c6_gnt", 32'(core_gnt), 32'h0);
      rst = 1'b0; core_done = '0; tick();
      check("c6_rerun", 32'(core_run), 32'hF);
      tick(); check("c6_notdone", done, 32'h0);

      // Zero enable mask with other bits set.
      host_start = '0; tick();
      host_start = 32'h100; tick();
      check("c4_d1", done, 32'h0);
      check("c4_run1", 32'(core_run), 32'h0);
      tick();
      check("c4_d2", done, 32'hFF);
      check("c4_run2", 32'(core_run), 32'h0);

      // Abort in the middle of a write burst.
      host_start = '0; tick();
      host_start = 32'h2; tick();
      core_req = 4'b0010; core_we = 16'h00F0; tick();
      check("c5_gnt", 32'(core_gnt), 32'h2);
      check("c5_we", 32'(BRAM_WE_A), 32'hF);
      host_start = '0; tick();
      check("c5_run", 32'(core_run), 32'h0);
      check("c5_gnt0", 32'(core_gnt), 32'h0);
      check("c5_we0", 32'(BRAM_WE_A), 32'h0);
      check("c5_done", done, 32'h0);
      core_req = '0; core_we = '0; tick();

      // Randomized traffic.
      for (int c = 0; c < 3000; c++) begin
         rst = ($urandom_range(0, 399) == 0);
         if (host_start == 32'd0) begin
            if ($urandom_range(0, 1) == 1) host_start = $urandom & 32'h1FF;
         end else if ($urandom_range(0, 79) == 0) begin
            host_start = '0;
         end
         if (host_start == 32'd0) core_done = '0;
         for (int i = 0; i < N; i++) begin
            if (host_start != 32'd0 && $urandom_range(0, 39) == 0) core_done[i] = 1'b1;
            if (core_req[i]) begin
               if (m_owner == i) begin
                  if (burst[i] == 0) core_req[i] = 1'b0;
                  else burst[i]--;
               end else if ($urandom_range(0, 49) == 0) begin
                  core_req[i] = 1'b0;
               end
            end else if ($urandom_range(0, 5) == 0) begin
               core_req[i] = 1'b1;
               burst[i] = $urandom_range(0, 4);
            end
            core_addr[i*32 +: 32]   = $urandom;
            core_wrdata[i*32 +: 32] = $urandom;
         end
         core_we = 16'($urandom);
         BRAM_RdData_A = $urandom;
         tick();
      end

      rst = 1'b0; host_start = '0; core_req = '0; tick(); tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/bcrypt_arbiter.md
BCRYPT_ARBITER -- requirements
Module: bcrypt_arbiter

Interface
REQ-001 SHALL have parameter NUM_CORES, default 4, the number of bcrypt_loop cores that share one host BRAM port.
REQ-002 SHALL have parameter REGION_STRIDE, default 32'h1100, the byte offset between per-core BRAM regions.
REQ-003 SHALL have parameter RD_LATENCY, default 2, the host BRAM read latency in cycles.
REQ-004 SHALL have ports as listed below. One clock; reset is synchronous and active-high.
- clk  in  1  sole clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- host_start  in  32  0 = abort/idle; nonzero = go; bits [NUM_CORES-1:0] = core enable mask.
- core_run  out  NUM_CORES  per-core run level, driven to each core's slv_reg0 input.
- core_done  in  NUM_CORES  per-core done (core done register != 0).
- core_req  in  NUM_CORES  per-core BRAM request, held high for a whole burst.
- core_gnt  out  NUM_CORES  one-hot-or-zero BRAM grant.
- core_addr  in  NUM_CORES*32  per-core region-relative byte address.
- core_we  in  NUM_CORES*4  per-core byte write enables.
- core_wrdata  in  NUM_CORES*32  per-core write data.
- core_rddata  out  32  BRAM_RdData_A broadcast to all cores.
- BRAM_Clk_A, BRAM_Rst_A, BRAM_En_A  out  1  = clk, 0, 1.
- BRAM_WE_A  out  4, BRAM_Addr_A  out  32, BRAM_WrData_A  out  32, BRAM_RdData_A  in  32: host BRAM port A.
- done  out  32  32'hFF when the job is complete, else 0.

Function
REQ-005 SHALL implement top FSM IDLE -> RUN -> DONE; any cycle with host_start == 0 forces IDLE the next cycle, from any state.
REQ-006 In IDLE with host_start != 0: mask = host_start[NUM_CORES-1:0]; if mask == 0, go to DONE; else latch mask and go to RUN.
REQ-007 In RUN: core_run[i] = mask[i]; a disabled core's core_req is ignored.
REQ-008 RUN -> DONE when (core_done & mask) == mask; core_run stays high in DONE, so cores retain their done state.
REQ-009 In DONE: done = 32'hFF, held until host_start returns to 0.
REQ-010 Arbitration: round-robin, starting from the index after the last granted core; after reset, core 0 has highest priority.
REQ-011 A grant SHALL be held while the granted core's req stays high; no preemption.
REQ-012 After the owner drops req, no new grant for RD_LATENCY cycles (guard), so in-flight read data reaches the owner.
REQ-013 The grant decision is registered: core_gnt[i] rises 1 cycle after an eligible core_req[i] rises on an idle, unguarded port.
REQ-014 When core_gnt[i] = 1:
- BRAM_Addr_A = core_addr[i] + i*REGION_STRIDE (32-bit, wrap ignored);
- BRAM_WE_A = core_we[i];
- BRAM_WrData_A = core_wrdata[i].
These are combinational from the grant.
REQ-015 When no grant: BRAM_WE_A = 0, BRAM_Addr_A = 0, BRAM_WrData_A = 0.
REQ-016 On simultaneous requests, exactly one core is granted per REQ-010; the others wait with core_gnt = 0.
REQ-017 On abort (host_start = 0): core_run, core_gnt and BRAM_WE_A = 0 on the next cycle; guard counter cleared; round-robin pointer kept.

Reset
REQ-018 rst SHALL force, on the next edge:
- FSM = IDLE, mask = 0, core_run = 0, core_gnt = 0, done = 0, guard = 0;
- round-robin pointer = NUM_CORES-1 (core 0 next);
- BRAM_WE_A = 0.
rst overrides host_start.

Structure
REQ-019 The shared package bcrypt_pkg SHALL hold: FSM state encodings, the P_ARRAY/P_S0/P_EXP_KEY/P_SALT/COUNT_ADDR offsets, REGION_STRIDE default, done value 32'hFF.
REQ-020 The round-robin grant logic SHALL be one sub-module, rr_arbiter (req, release -> registered one-hot grant).

Verification
REQ-021 host_start = 32'h3; core 0 and core 1 assert req in the same cycle -> core_gnt = 4'b0001 next cycle; core 1 is granted RD_LATENCY+1 cycles after core 0 drops req.
REQ-022 Core 2 granted, core_addr = 32'd4260 -> BRAM_Addr_A = 32'h2200 + 4260 = 32'h32A4; core_we = 4'hF passes through; BRAM_WE_A = 0 the cycle after release.
REQ-023 mask = 4'b1111; cores assert done in order 3,1,0,2 -> done = 32'hFF exactly 1 cycle after core 2 asserts done, and not before.
REQ-024 host_start = 32'h100 (mask 0) -> done = 32'hFF 2 cycles later; core_run stays 0.
REQ-025 Mid-burst (core 1 granted, BRAM_WE_A = 4'hF), host_start -> 0 -> next cycle core_run = 0, core_gnt = 0, BRAM_WE_A = 0, done = 0.
REQ-026 rst asserted while in DONE with host_start != 0 -> all outputs at reset values next cycle; after rst drops, FSM re-enters RUN.
